// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side driver for the 16-bit ArithmeticUnit.
//
// Takes one instruction at a time over a valid/ready handshake. It drives one
// ALU operation select, the operands and the carry-in. It captures the ALU
// result and flags into the accumulator and flag registers, then pulses done.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    instruction handshake (ready only in IDLE)
//   in_op[3:0]           opcode
//   in_operand[15:0]     B operand
//   alu_A/alu_B          ALU operands (A = accumulator, B = latched operand)
//   alu_sel[9:0]         one-hot select: B15to0,AandB,AorB,notB,shlB,shrB,
//                        AaddB,AsubB,AmulB,AcmpB (bit 9..0)
//   alu_cin              ALU carry-in
//   alu_out/cout/zout    ALU result and flags
//   acc, c_flag, z_flag  accumulator and captured flags
//   err                  sticky illegal-opcode flag
//   done                 one-cycle completion pulse
//
// Parameter MUL_LAT (0..15): extra EXEC cycles held for multiply.
// Optional feature macro ALU_CARRY_CHAIN_EN: adds ADC (10) and SBB (11), which
// feed c_flag into alu_cin. When it is undefined those opcodes are illegal and
// alu_cin is tied low.
module alu_sequencer #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_operand,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [9:0]  alu_sel,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  input  logic        alu_zout,
  output logic [15:0] acc,
  output logic        c_flag,
  output logic        z_flag,
  output logic        err,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] MLAT   = 4'(MUL_LAT);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [9:0]  sel_dec;
  logic        accept;

  assign accept = in_valid && in_ready;
  assign alu_A  = acc;

  // Opcode to one-hot select. A zero result marks the opcode as illegal.
  always_comb begin
    sel_dec = '0;
    case (in_op)
      4'd0:    sel_dec = 10'b10_0000_0000;
      4'd1:    sel_dec = 10'b01_0000_0000;
      4'd2:    sel_dec = 10'b00_1000_0000;
      4'd3:    sel_dec = 10'b00_0100_0000;
      4'd4:    sel_dec = 10'b00_0010_0000;
      4'd5:    sel_dec = 10'b00_0001_0000;
      4'd6:    sel_dec = 10'b00_0000_1000;
      4'd7:    sel_dec = 10'b00_0000_0100;
      4'd8:    sel_dec = 10'b00_0000_0010;
      4'd9:    sel_dec = 10'b00_0000_0001;
`ifdef ALU_CARRY_CHAIN_EN
      4'd10:   sel_dec = 10'b00_0000_1000;  // ADC reuses the adder
      4'd11:   sel_dec = 10'b00_0000_0100;  // SBB reuses the subtractor
`endif
      default: sel_dec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      alu_B    <= '0;
      alu_sel  <= '0;
      acc      <= '0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            alu_B    <= in_operand;
            in_ready <= 1'b0;
            if (sel_dec != '0) begin
              state   <= EXEC;
              alu_sel <= sel_dec;
              cnt     <= (in_op == OP_MUL) ? MLAT : 4'd0;
            end else begin
              // Illegal opcode: no ALU activity, straight to the done pulse.
              state <= DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            alu_sel <= '0;
            if (op_q != OP_CMP) acc <= alu_out;
            c_flag <= alu_cout;
            z_flag <= alu_zout;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CARRY_CHAIN_EN
  // Carry-in is latched at accept from the current c_flag, so it stays stable
  // for the whole EXEC window even though c_flag is rewritten at capture.
  logic cin_q;

  always_ff @(posedge clk) begin
    if (rst)
      cin_q <= 1'b0;
    else if (state == IDLE && accept)
      cin_q <= (in_op == 4'd10 || in_op == 4'd11) && c_flag;
    else if (state == EXEC && cnt == 4'd0)
      cin_q <= 1'b0;
  end

  assign alu_cin = cin_q;
`else
  assign alu_cin = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_operand;
  logic [15:0] alu_A, alu_B, alu_out, acc;
  logic [9:0]  alu_sel;
  logic        alu_cin, alu_cout, alu_zout, c_flag, z_flag, err, done;

  alu_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_operand(in_operand), .alu_A(alu_A), .alu_B(alu_B),
    .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_out(alu_out),
    .alu_cout(alu_cout), .alu_zout(alu_zout), .acc(acc), .c_flag(c_flag),
    .z_flag(z_flag), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural ArithmeticUnit.
  logic [16:0] ar;
  logic [31:0] pr;
  always_comb begin
    ar = '0;
    pr = {16'b0, alu_A} * {16'b0, alu_B};
    case (alu_sel)
      10'h200: ar = {1'b0, alu_B};
      10'h100: ar = {1'b0, alu_A & alu_B};
      10'h080: ar = {1'b0, alu_A | alu_B};
      10'h040: ar = {1'b0, ~alu_B};
      10'h020: ar = {alu_B[15], alu_B[14:0], 1'b0};
      10'h010: ar = {alu_B[0], 1'b0, alu_B[15:1]};
      10'h008: ar = {1'b0, alu_A} + {1'b0, alu_B} + {16'b0, alu_cin};
      10'h004: ar = {1'b0, alu_A} - {1'b0, alu_B} - {16'b0, alu_cin};
      10'h002: ar = {|pr[31:16], pr[15:0]};
      10'h001: ar = {(alu_A < alu_B), alu_A};
      default: ar = '0;
    endcase
  end
  assign alu_out  = ar[15:0];
  assign alu_cout = ar[16];
  assign alu_zout = (alu_sel == 10'h001) ? (alu_A == alu_B) : (ar[15:0] == 16'h0);

  typedef struct {
    logic [3:0]  op;
    logic [15:0] opnd;
    logic [9:0]  sel;
    logic        cin;
    logic [15:0] acc;
    logic        c;
    logic        z;
    logic        err;
    int          n;    // EXEC cycles, equal to accept-to-done edge count
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  vec_t mon_e;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] opnd,
                              input logic [9:0] sel, input logic cin,
                              input logic [15:0] a, input logic c, input logic z,
                              input logic e, input int n);
    vec_t v;
    v.op = op; v.opnd = opnd; v.sel = sel; v.cin = cin;
    v.acc = a; v.c = c; v.z = z; v.err = e; v.n = n;
    return v;
  endfunction

  // Monitor: accept timestamps on the rising edge, sampling on the falling edge.
  int          cyc = 0, acc_cyc = 0, exec_n = 0, n_done = 0, n_acc = 0;
  logic [9:0]  sel_or = '0;
  logic        cin_or = 1'b0, cin_stray = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) begin
      acc_cyc = cyc; n_acc++; exec_n = 0; sel_or = '0; cin_or = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exec_n = 0; sel_or = '0; cin_or = 1'b0;
    end else begin
      if (alu_sel != '0) begin
        exec_n++; sel_or |= alu_sel; cin_or |= alu_cin;
      end else if (alu_cin) begin
        cin_stray = 1'b1;
      end
      if (done) begin
        n_done++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("sel",  32'(sel_or), 32'(mon_e.sel));
          chk("cin",  32'(cin_or), 32'(mon_e.cin));
          chk("exec", exec_n, mon_e.n);
          chk("lat",  cyc - acc_cyc, mon_e.n);
          chk("acc",  32'(acc), 32'(mon_e.acc));
          chk("c",    32'(c_flag), 32'(mon_e.c));
          chk("z",    32'(z_flag), 32'(mon_e.z));
          chk("err",  32'(err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic run_op(input vec_t v);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = v.op; in_operand = v.opnd;
    sbq.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!done && t < 40) begin @(negedge clk); t++; end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, rdy_hi, a0, d0;
    vec_t hv;

    tbl.push_back(mk(4'd0,  16'h000D, 10'h200, 0, 16'h000D, 0, 0, 0, 1));
    tbl.push_back(mk(4'd1,  16'h000D, 10'h100, 0, 16'h000D, 0, 0, 0, 1));
    tbl.push_back(mk(4'd2,  16'h0002, 10'h080, 0, 16'h000F, 0, 0, 0, 1));
    tbl.push_back(mk(4'd7,  16'h000F, 10'h004, 0, 16'h0000, 0, 1, 0, 1));
    tbl.push_back(mk(4'd0,  16'h000D, 10'h200, 0, 16'h000D, 0, 0, 0, 1));
    tbl.push_back(mk(4'd9,  16'h000D, 10'h001, 0, 16'h000D, 0, 1, 0, 1));
    tbl.push_back(mk(4'd8,  16'h0003, 10'h002, 0, 16'h0027, 0, 0, 0, 1 + MUL_LAT));
    tbl.push_back(mk(4'd3,  16'h00F0, 10'h040, 0, 16'hFF0F, 0, 0, 0, 1));
    tbl.push_back(mk(4'd4,  16'h8001, 10'h020, 0, 16'h0002, 1, 0, 0, 1));
    tbl.push_back(mk(4'd5,  16'h0001, 10'h010, 0, 16'h0000, 1, 1, 0, 1));
    tbl.push_back(mk(4'd0,  16'hFFFF, 10'h200, 0, 16'hFFFF, 0, 0, 0, 1));
    tbl.push_back(mk(4'd6,  16'h0001, 10'h008, 0, 16'h0000, 1, 1, 0, 1));
`ifdef ALU_CARRY_CHAIN_EN
    tbl.push_back(mk(4'd10, 16'h0000, 10'h008, 1, 16'h0001, 0, 0, 0, 1));
    tbl.push_back(mk(4'd7,  16'h0002, 10'h004, 0, 16'hFFFF, 1, 0, 0, 1));
    tbl.push_back(mk(4'd11, 16'h0001, 10'h004, 1, 16'hFFFD, 0, 0, 0, 1));
    tbl.push_back(mk(4'd15, 16'h0000, 10'h000, 0, 16'hFFFD, 0, 0, 1, 0));
    tbl.push_back(mk(4'd12, 16'h1111, 10'h000, 0, 16'hFFFD, 0, 0, 1, 0));
    hv = mk(4'd8, 16'h0003, 10'h002, 0, 16'hFFF7, 1, 0, 1, 1 + MUL_LAT);
`else
    tbl.push_back(mk(4'd10, 16'h0000, 10'h000, 0, 16'h0000, 1, 1, 1, 0));
    tbl.push_back(mk(4'd7,  16'h0002, 10'h004, 0, 16'hFFFE, 1, 0, 1, 1));
    tbl.push_back(mk(4'd11, 16'h0001, 10'h000, 0, 16'hFFFE, 1, 0, 1, 0));
    tbl.push_back(mk(4'd15, 16'h0000, 10'h000, 0, 16'hFFFE, 1, 0, 1, 0));
    hv = mk(4'd8, 16'h0003, 10'h002, 0, 16'hFFFA, 1, 0, 1, 1 + MUL_LAT);
`endif

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_operand = '0;
    repeat (3) @(negedge clk);
    chk("rst_acc",   32'(acc), 32'h0);
    chk("rst_c",     32'(c_flag), 32'h0);
    chk("rst_z",     32'(z_flag), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_sel",   32'(alu_sel), 32'h0);
    chk("rst_A",     32'(alu_A), 32'h0);
    chk("rst_B",     32'(alu_B), 32'h0);
    chk("rst_cin",   32'(alu_cin), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_op(tbl[i]);

    // MUL with in_valid held high the whole time: exactly one accept.
    a0 = n_acc; rdy_hi = 0; t = 0;
    sbq.push_back(hv);
    in_valid = 1'b1; in_op = hv.op; in_operand = hv.opnd;
    @(negedge clk);
    while (!done && t < 40) begin
      if (in_ready) rdy_hi++;
      @(negedge clk); t++;
    end
    if (!done) chk("hold_done_timeout", 32'(done), 32'd1);
    in_valid = 1'b0;
    chk("hold_accepts", n_acc - a0, 1);
    chk("hold_ready_low", rdy_hi, 0);
    @(negedge clk);

    // Reset during MUL EXEC: everything back to reset values, no done pulse.
    in_valid = 1'b1; in_op = 4'd8; in_operand = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_in_exec", 32'(alu_sel), 32'h002);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'h1);
    chk("abort_acc",   32'(acc), 32'h0);
    chk("abort_sel",   32'(alu_sel), 32'h0);
    chk("abort_done",  32'(done), 32'h0);
    chk("abort_err",   32'(err), 32'h0);
    chk("abort_c",     32'(c_flag), 32'h0);
    chk("abort_B",     32'(alu_B), 32'h0);
    rst = 1'b0;
    d0 = n_done;
    repeat (6) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

    run_op(mk(4'd0, 16'h1234, 10'h200, 0, 16'h1234, 0, 0, 0, 1));
    chk("cin_stray", 32'(cin_stray), 32'h0);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
